// File: rtl/ctrl_types_pkg.sv
// Shared controller types: sub-command status and the SET responder state encoding.
// Used by set_fsm (optional SET_FSM_DUP_CHECK_EN build adds a duplicate-key check).
package ctrl_types_pkg;

    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_DONE,
        S_ERR
    } set_state_e;

endpackage

// File: rtl/set_fsm_if.sv
// Controller <-> SET responder signal bundle; master is the controller side.
// `hit` exists only when SET_FSM_DUP_CHECK_EN is defined.
interface set_fsm_if
    import ctrl_types_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 16
);
    logic                   en;
    logic                   enter;
    logic [NUM_ENTRIES-1:0] used;
`ifdef SET_FSM_DUP_CHECK_EN
    logic [NUM_ENTRIES-1:0] hit;
`endif
    logic [NUM_ENTRIES-1:0] idx_out;
    logic                   write_out;
    sub_cmd_t               cmd;

`ifdef SET_FSM_DUP_CHECK_EN
    modport master (output en, enter, used, hit, input idx_out, write_out, cmd);
    modport slave  (input en, enter, used, hit, output idx_out, write_out, cmd);
`else
    modport master (output en, enter, used, input idx_out, write_out, cmd);
    modport slave  (input en, enter, used, output idx_out, write_out, cmd);
`endif
endinterface

// File: rtl/free_slot_finder.sv
// Combinational lowest-zero priority encoder over one LANES-wide chunk.
module free_slot_finder #(
    parameter int unsigned LANES = 16
) (
    input  logic [LANES-1:0] bits_i,
    output logic             found_o,
    output logic [LANES-1:0] sel_o
);

    always_comb begin
        found_o = 1'b0;
        sel_o   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!found_o && !bits_i[i]) begin
                found_o  = 1'b1;
                sel_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_fsm.sv
// CREATE-path sub-command responder: snapshot `used`, find lowest free entry, strobe write.
// SET_FSM_DUP_CHECK_EN adds an error-on-existing-key check at entry.
module set_fsm
    import ctrl_types_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned LANES       = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    set_fsm_if.slave  bus
);

    localparam int unsigned NCHUNK = NUM_ENTRIES / LANES;
    localparam int unsigned PW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (LANES == 0 || (NUM_ENTRIES % LANES) != 0) begin : g_lanes_chk
        $error("set_fsm: LANES must divide NUM_ENTRIES");
    end

    set_state_e             state_q;
    logic [PW-1:0]          ptr_q;
    logic [NUM_ENTRIES-1:0] snap_q;
    logic [NUM_ENTRIES-1:0] idx_q;
    logic                   write_q;
    logic                   done_q;
    logic                   err_q;

    logic [LANES-1:0]       chunk;
    logic [LANES-1:0]       sel;
    logic                   found;
    logic [NUM_ENTRIES-1:0] glob_sel;
    logic                   last_chunk;
    logic                   dup_hit;

    always_comb begin
        chunk = '0;
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            if (ptr_q == PW'(c)) chunk = snap_q[c*LANES +: LANES];
        end
    end

    free_slot_finder #(.LANES(LANES)) u_finder (
        .bits_i  (chunk),
        .found_o (found),
        .sel_o   (sel)
    );

    // Place the chunk-local one-hot back at its global position.
    always_comb begin
        glob_sel = '0;
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            if (ptr_q == PW'(c)) glob_sel[c*LANES +: LANES] = sel;
        end
    end

    assign last_chunk = (ptr_q == PW'(NCHUNK - 1));

`ifdef SET_FSM_DUP_CHECK_EN
    assign dup_hit = |(bus.hit & bus.used);
`else
    assign dup_hit = 1'b0;
`endif

    // Outputs are registered alongside the state they belong to, so they stay Moore.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (bus.enter) begin
                snap_q <= bus.used;
                ptr_q  <= '0;
                if (dup_hit) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end else begin
                    state_q <= S_SCAN;
                end
            end else if (state_q != S_IDLE && !bus.en) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (found) begin
                            state_q <= S_WRITE;
                            idx_q   <= glob_sel;
                            write_q <= 1'b1;
                        end else if (last_chunk) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + PW'(1);
                        end
                    end
                    S_WRITE: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    S_ERR:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.idx_out   = idx_q;
    assign bus.write_out = write_q;
    assign bus.cmd.done  = done_q;
    assign bus.cmd.error = err_q;

endmodule
